bp_be_issue_queue: RTL and testbench

- Parametrised, rollback-capable issue buffer between the FE queue interface and the BE scheduler.
- Holds FE queue packets with three pointers:
  - write (enqueue)
  - issue (dispatch)
  - commit (retire)
- Issued-but-uncommitted entries can be replayed on a poison/rollback, which a plain ready/valid FE queue cannot do.
- Supports replay after an interrupt or a mispredict, and flush on FE redirect.

---
 rtl/bp_be_issue_queue.sv | 104 ++++++++++
 tb/tb_bp_be_issue_queue.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_issue_queue.sv
// Rollback-capable issue buffer: write, issue and commit pointers over one array.
// Define BP_BE_ISSUE_QUEUE_BYPASS_EN for a zero-latency enqueue-to-issue bypass.
module bp_be_issue_queue #(
  parameter int els_p   = 8,
  parameter int width_p = 128,
  localparam int ptr_width_lp = $clog2(els_p) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [width_p-1:0]      fe_queue_i,
  input  logic                    fe_queue_v_i,
  output logic                    fe_queue_ready_o,
  output logic [width_p-1:0]      issue_o,
  output logic                    issue_v_o,
  input  logic                    issue_yumi_i,
  input  logic                    commit_v_i,
  input  logic                    roll_v_i,
  input  logic                    clr_v_i,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [ptr_width_lp-1:0] count_o
);

  localparam int idx_w_lp = $clog2(els_p);

  logic [ptr_width_lp-1:0] wptr_q, wptr_d;
  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [ptr_width_lp-1:0] cptr_q, cptr_d;
  logic [width_p-1:0]      mem_q [els_p];

  logic [ptr_width_lp-1:0] occ;
  logic                    full;
  logic                    enq;

  assign occ  = wptr_q - cptr_q;
  assign full = (occ == ptr_width_lp'(els_p));
  assign enq  = fe_queue_v_i & ~full & ~clr_v_i;

  assign fe_queue_ready_o = ~full;
  assign full_o           = full;
  assign empty_o          = (wptr_q == cptr_q);
  assign count_o          = occ;

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
  logic byp;
  assign byp = (rptr_q == wptr_q) & ~roll_v_i & ~clr_v_i;
  assign issue_v_o = byp ? (fe_queue_v_i & ~full)
                         : (rptr_q != wptr_q);
  assign issue_o   = byp ? fe_queue_i
                         : mem_q[rptr_q[idx_w_lp-1:0]];
`else
  assign issue_v_o = (rptr_q != wptr_q);
  assign issue_o   = mem_q[rptr_q[idx_w_lp-1:0]];
`endif

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cptr_d = cptr_q;
    if (clr_v_i) begin
      rptr_d = wptr_q;
      cptr_d = wptr_q;
    end else begin
      wptr_d = wptr_q + ptr_width_lp'(enq);
      cptr_d = cptr_q + ptr_width_lp'(commit_v_i);
      // Rollback targets the post-commit pointer and overrides a yumi
      if (roll_v_i)
        rptr_d = cptr_d;
      else
        rptr_d = rptr_q + ptr_width_lp'(issue_yumi_i);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq)
      mem_q[wptr_q[idx_w_lp-1:0]] <= fe_queue_i;
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(issue_yumi_i && !issue_v_o))
        else $error("issue_yumi_i without issue_v_o");
      assert (!(commit_v_i && (cptr_q == rptr_q)))
        else $error("commit_v_i with nothing issued");
      assert ((els_p & (els_p - 1)) == 0)
        else $error("els_p must be a power of two");
    end
  end
`endif

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Directed bench for bp_be_issue_queue with els_p=4.
// Bypass scenario is selected with BP_BE_ISSUE_QUEUE_BYPASS_EN.
module tb_bp_be_issue_queue;

  localparam int E = 4;
  localparam int W = 16;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [W-1:0] fe_queue_i;
  logic         fe_queue_v_i;
  logic         fe_queue_ready_o;
  logic [W-1:0] issue_o;
  logic         issue_v_o;
  logic         issue_yumi_i;
  logic         commit_v_i;
  logic         roll_v_i;
  logic         clr_v_i;
  logic         empty_o;
  logic         full_o;
  logic [2:0]   count_o;

  int checks = 0;
  int errors = 0;

  localparam logic [W-1:0] VA = 16'hA0A0;
  localparam logic [W-1:0] VB = 16'hB1B1;
  localparam logic [W-1:0] VC = 16'hC2C2;
  localparam logic [W-1:0] VD = 16'hD3D3;
  localparam logic [W-1:0] VE = 16'hE4E4;
  localparam logic [W-1:0] VF = 16'hF5F5;

  bp_be_issue_queue #(.els_p(E), .width_p(W)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .issue_o          (issue_o),
    .issue_v_o        (issue_v_o),
    .issue_yumi_i     (issue_yumi_i),
    .commit_v_i       (commit_v_i),
    .roll_v_i         (roll_v_i),
    .clr_v_i          (clr_v_i),
    .empty_o          (empty_o),
    .full_o           (full_o),
    .count_o          (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle;
    fe_queue_v_i = 1'b0;
    issue_yumi_i = 1'b0;
    commit_v_i   = 1'b0;
    roll_v_i     = 1'b0;
    clr_v_i      = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] d);
    fe_queue_v_i = 1'b1;
    fe_queue_i   = d;
    tick();
    fe_queue_v_i = 1'b0;
  endtask

  task automatic flush;
    idle();
    clr_v_i = 1'b1;
    tick();
    clr_v_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    idle();
    fe_queue_i = '0;
    #3;
    checks++;
    if (fe_queue_ready_o !== 1'b1 || issue_v_o !== 1'b0 ||
        empty_o !== 1'b1 || full_o !== 1'b0 || count_o !== 3'd0) begin
      errors++;
      $display("FAIL reset: rdy=%b v=%b emp=%b full=%b cnt=%0d req 1 0 1 0 0",
               fe_queue_ready_o, issue_v_o, empty_o, full_o, count_o);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_full;
    push(VA); push(VB); push(VC); push(VD);
    fe_queue_v_i = 1'b1;
    fe_queue_i   = VE;
    #1;
    checks++;
    if (full_o !== 1'b1 || count_o !== 3'd4 || fe_queue_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full: full=%b cnt=%0d rdy=%b req 1 4 0",
               full_o, count_o, fe_queue_ready_o);
    end
    tick();
    checks++;
    if (count_o !== 3'd4 || issue_o !== VA) begin
      errors++;
      $display("FAIL full_hold: cnt=%0d head=%h req 4 %h", count_o, issue_o, VA);
    end
    issue_yumi_i = 1'b1;
    tick();
    issue_yumi_i = 1'b0;
    commit_v_i   = 1'b1;
    #1;
    checks++;
    if (fe_queue_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_commit_rdy: rdy=%b req 0", fe_queue_ready_o);
    end
    tick();
    commit_v_i = 1'b0;
    #1;
    checks++;
    if (fe_queue_ready_o !== 1'b1 || count_o !== 3'd3) begin
      errors++;
      $display("FAIL full_freed: rdy=%b cnt=%0d req 1 3", fe_queue_ready_o, count_o);
    end
    tick();
    fe_queue_v_i = 1'b0;
    #1;
    checks++;
    if (count_o !== 3'd4 || issue_o !== VB) begin
      errors++;
      $display("FAIL full_accept: cnt=%0d head=%h req 4 %h", count_o, issue_o, VB);
    end
    flush();
  endtask

  task automatic test_roll;
    push(VA); push(VB); push(VC);
    issue_yumi_i = 1'b1;
    tick(); tick();
    issue_yumi_i = 1'b0;
    commit_v_i   = 1'b1;
    tick();
    commit_v_i = 1'b0;
    roll_v_i   = 1'b1;
    tick();
    roll_v_i = 1'b0;
    #1;
    checks++;
    if (issue_o !== VB || issue_v_o !== 1'b1 || count_o !== 3'd2) begin
      errors++;
      $display("FAIL roll: head=%h v=%b cnt=%0d req %h 1 2",
               issue_o, issue_v_o, count_o, VB);
    end
    issue_yumi_i = 1'b1;
    tick();
    checks++;
    if (issue_o !== VC || issue_v_o !== 1'b1) begin
      errors++;
      $display("FAIL roll_replay: head=%h v=%b req %h 1", issue_o, issue_v_o, VC);
    end
    tick();
    issue_yumi_i = 1'b0;
    #1;
    checks++;
    if (issue_v_o !== 1'b0 || count_o !== 3'd2) begin
      errors++;
      $display("FAIL roll_drain: v=%b cnt=%0d req 0 2", issue_v_o, count_o);
    end
    flush();
  endtask

  task automatic test_commit_roll_yumi;
    push(VA); push(VB); push(VC);
    issue_yumi_i = 1'b1;
    tick(); tick();
    commit_v_i = 1'b1;
    roll_v_i   = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if (issue_o !== VB || issue_v_o !== 1'b1 || count_o !== 3'd2) begin
      errors++;
      $display("FAIL cry: head=%h v=%b cnt=%0d req %h 1 2",
               issue_o, issue_v_o, count_o, VB);
    end
    issue_yumi_i = 1'b1;
    tick();
    issue_yumi_i = 1'b0;
    #1;
    checks++;
    if (issue_o !== VC) begin
      errors++;
      $display("FAIL cry_next: head=%h req %h", issue_o, VC);
    end
    flush();
  endtask

  task automatic test_clear;
    push(VA); push(VB); push(VC);
    clr_v_i      = 1'b1;
    fe_queue_v_i = 1'b1;
    fe_queue_i   = VD;
    tick();
    idle();
    #1;
    checks++;
    if (empty_o !== 1'b1 || count_o !== 3'd0 || issue_v_o !== 1'b0) begin
      errors++;
      $display("FAIL clear: emp=%b cnt=%0d v=%b req 1 0 0",
               empty_o, count_o, issue_v_o);
    end
    push(VF);
    #1;
    checks++;
    if (issue_v_o !== 1'b1 || issue_o !== VF || count_o !== 3'd1) begin
      errors++;
      $display("FAIL clear_drop: v=%b head=%h cnt=%0d req 1 %h 1",
               issue_v_o, issue_o, count_o, VF);
    end
    flush();
  endtask

  task automatic test_latency;
    fe_queue_v_i = 1'b1;
    fe_queue_i   = VE;
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
    issue_yumi_i = 1'b1;
    #1;
    checks++;
    if (issue_v_o !== 1'b1 || issue_o !== VE) begin
      errors++;
      $display("FAIL bypass: v=%b head=%h req 1 %h", issue_v_o, issue_o, VE);
    end
    tick();
    idle();
    #1;
    checks++;
    if (count_o !== 3'd1 || issue_v_o !== 1'b0) begin
      errors++;
      $display("FAIL bypass_next: cnt=%0d v=%b req 1 0", count_o, issue_v_o);
    end
    roll_v_i = 1'b1;
    tick();
    roll_v_i = 1'b0;
    #1;
    checks++;
    if (issue_v_o !== 1'b1 || issue_o !== VE) begin
      errors++;
      $display("FAIL bypass_roll: v=%b head=%h req 1 %h", issue_v_o, issue_o, VE);
    end
`else
    #1;
    checks++;
    if (issue_v_o !== 1'b0) begin
      errors++;
      $display("FAIL latency0: v=%b req 0", issue_v_o);
    end
    tick();
    fe_queue_v_i = 1'b0;
    #1;
    checks++;
    if (issue_v_o !== 1'b1 || issue_o !== VE || count_o !== 3'd1) begin
      errors++;
      $display("FAIL latency1: v=%b head=%h cnt=%0d req 1 %h 1",
               issue_v_o, issue_o, count_o, VE);
    end
`endif
    flush();
  endtask

  task automatic test_wrap;
    int sent = 0;
    int issued = 0;
    int committed = 0;
    int cyc = 0;
    logic acc;
    logic yum;
    logic com;
    while (committed < 20 && cyc < 200) begin
      fe_queue_v_i = (sent < 20);
      fe_queue_i   = W'(16'h100 + sent);
      com          = (issued > committed);
      commit_v_i   = com;
      #1;
      yum          = issue_v_o;
      issue_yumi_i = yum;
      #1;
      checks++;
      if (count_o !== 3'(sent - committed) || count_o > 3'd4) begin
        errors++;
        $display("FAIL wrap_count: cyc=%0d cnt=%0d req %0d",
                 cyc, count_o, sent - committed);
      end
      if (yum) begin
        checks++;
        if (issue_o !== W'(16'h100 + issued)) begin
          errors++;
          $display("FAIL wrap_order: cyc=%0d head=%h req %h",
                   cyc, issue_o, W'(16'h100 + issued));
        end
      end
      acc = fe_queue_v_i & fe_queue_ready_o;
      tick();
      sent      += int'(acc);
      issued    += int'(yum);
      committed += int'(com);
      cyc++;
    end
    idle();
    #1;
    checks++;
    if (committed != 20 || issued != 20 || empty_o !== 1'b1) begin
      errors++;
      $display("FAIL wrap_done: committed=%0d issued=%0d emp=%b req 20 20 1",
               committed, issued, empty_o);
    end
  endtask

  task automatic test_async_reset;
    push(VA); push(VB);
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (count_o !== 3'd0 || empty_o !== 1'b1 || issue_v_o !== 1'b0 ||
        fe_queue_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: cnt=%0d emp=%b v=%b rdy=%b req 0 1 0 1",
               count_o, empty_o, issue_v_o, fe_queue_ready_o);
    end
    reset_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_full();
    test_roll();
    test_commit_roll_yumi();
    test_clear();
    test_latency();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
